// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared constants and types for the FPU issue controller and its latency lookup.
package fpu_issue_ctrl_pkg;
  localparam int TAG_W = 5;

  localparam logic [3:0] LAT_ADD  = 4'd2;
  localparam logic [3:0] LAT_MUL  = 4'd1;
  localparam logic [3:0] LAT_DIV  = 4'd4;
  localparam logic [3:0] LAT_SQRT = 4'd4;
  localparam logic [3:0] LAT_CVT  = 4'd2;
  localparam logic [3:0] LAT_MISC = 4'd1;

  localparam logic [6:0] F7_ADD  = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h04;
  localparam logic [6:0] F7_MUL  = 7'h08;
  localparam logic [6:0] F7_DIV  = 7'h0C;
  localparam logic [6:0] F7_SGNJ = 7'h10;
  localparam logic [6:0] F7_SQRT = 7'h2C;
  localparam logic [6:0] F7_CMP  = 7'h50;
  localparam logic [6:0] F7_CVT  = 7'h68;
  localparam logic [6:0] F7_MVWS = 7'h70;
  localparam logic [6:0] F7_MVSW = 7'h78;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operation as presented to the FPU datapath.
  typedef struct packed {
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] x1;
    logic [31:0] x2;
  } fpu_op_t;
endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request, FPU-side and result signals of the issue controller.
// master = core/FPU side, slave = the controller.
interface fpu_issue_ctrl_if
  import fpu_issue_ctrl_pkg::*;
();
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_funct7;
  logic [2:0]       req_funct3;
  logic [31:0]      req_x1;
  logic [31:0]      req_x2;
  logic [TAG_W-1:0] req_tag;
  logic [6:0]       fpu_funct7;
  logic [2:0]       fpu_funct3;
  logic [31:0]      fpu_x1;
  logic [31:0]      fpu_x2;
  logic [31:0]      fpu_y;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_illeg;
  logic             busy;

  modport master (
    output flush, req_valid, req_funct7, req_funct3, req_x1, req_x2, req_tag,
           fpu_y, res_ready,
    input  req_ready, fpu_funct7, fpu_funct3, fpu_x1, fpu_x2,
           res_valid, res_data, res_tag, res_illeg, busy
  );

  modport slave (
    input  flush, req_valid, req_funct7, req_funct3, req_x1, req_x2, req_tag,
           fpu_y, res_ready,
    output req_ready, fpu_funct7, fpu_funct3, fpu_x1, fpu_x2,
           res_valid, res_data, res_tag, res_illeg, busy
  );
endinterface

// File: rtl/fpu_issue_ctrl_lat_lut.sv
// funct7 -> fixed FPU latency and illegal-op flag; purely combinational so the
// hazard unit can reuse it.
module fpu_lat_lut
  import fpu_issue_ctrl_pkg::*;
(
  input  logic [6:0] funct7,
  output logic [3:0] lat,
  output logic       illeg
);
  // Decode latency class; anything outside the known set runs as misc and is flagged.
  always_comb begin
    lat   = LAT_MISC;
    illeg = 1'b0;
    case (funct7)
      F7_ADD, F7_SUB:                   lat = LAT_ADD;
      F7_MUL:                           lat = LAT_MUL;
      F7_DIV:                           lat = LAT_DIV;
      F7_SQRT:                          lat = LAT_SQRT;
      F7_CVT:                           lat = LAT_CVT;
      F7_SGNJ, F7_CMP, F7_MVWS, F7_MVSW: lat = LAT_MISC;
      default:                          illeg = 1'b1;
    endcase
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller: latches one FP op, holds it on the FPU
// inputs for the op's fixed latency, captures the result and presents it with its tag.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fpu_issue_ctrl_if.slave bus
);
  state_t           state, state_n;
  logic [3:0]       cnt;
  fpu_op_t          op_q;
  logic [TAG_W-1:0] tag_q;
  logic             illeg_q;
  logic [31:0]      res_data_q;
  logic [3:0]       lut_lat;
  logic             lut_illeg;
  logic             accept;

  fpu_lat_lut u_lat_lut (
    .funct7 (bus.req_funct7),
    .lat    (lut_lat),
    .illeg  (lut_illeg)
  );

  // A new op may enter when idle, or when the pending result retires this same cycle.
  assign bus.req_ready = !bus.flush &&
                         (state == S_IDLE || (state == S_DONE && bus.res_ready));
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.fpu_funct7 = op_q.funct7;
  assign bus.fpu_funct3 = op_q.funct3;
  assign bus.fpu_x1     = op_q.x1;
  assign bus.fpu_x2     = op_q.x2;
  assign bus.res_valid  = (state == S_DONE);
  assign bus.res_data   = res_data_q;
  assign bus.res_tag    = tag_q;
  assign bus.res_illeg  = illeg_q;
  assign bus.busy       = (state != S_IDLE);

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_n = state;
    if (bus.flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) state_n = S_EXEC;
        S_EXEC: if (cnt == 4'd0) state_n = S_DONE;
        S_DONE: begin
          if (accept)             state_n = S_EXEC;
          else if (bus.res_ready) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State, op latch, latency countdown and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      tag_q      <= '0;
      illeg_q    <= 1'b0;
      res_data_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q    <= '{funct7: bus.req_funct7, funct3: bus.req_funct3,
                     x1: bus.req_x1, x2: bus.req_x2};
        tag_q   <= bus.req_tag;
        illeg_q <= lut_illeg;
        cnt     <= lut_lat - 4'd1;
      end else if (state == S_EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_EXEC && cnt == 4'd0 && !bus.flush)
        res_data_q <= bus.fpu_y;
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (one op in flight, result due a fixed number of cycles later).
module tb_fpu_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  // Transaction model state
  bit          have_op = 1'b0;
  int          rdy_cyc = 0;
  logic [6:0]  e_f7;
  logic [2:0]  e_f3;
  logic [31:0] e_x1, e_x2;
  logic [4:0]  e_tag;
  bit          exp_ready, obs_ready;

  function automatic int ref_lat(input logic [6:0] f);
    case (f)
      7'h00, 7'h04: return 2;
      7'h08:        return 1;
      7'h0C, 7'h2C: return 4;
      7'h68:        return 2;
      default:      return 1;
    endcase
  endfunction

  function automatic bit ref_illeg(input logic [6:0] f);
    case (f)
      7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h2C, 7'h50, 7'h68, 7'h70, 7'h78: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Stand-in FPU: a few exact IEEE results, x1^x2 for unknown ops, a mix otherwise.
  function automatic logic [31:0] fake_fpu(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [31:0] x1, input logic [31:0] x2);
    if (f7 == 7'h00 && x1 == 32'h3F800000 && x2 == 32'h40000000) return 32'h40400000;
    if (f7 == 7'h08 && x1 == 32'h40000000 && x2 == 32'h40400000) return 32'h40C00000;
    if (f7 == 7'h0C && x1 == 32'h40C00000 && x2 == 32'h40000000) return 32'h40400000;
    if (ref_illeg(f7)) return x1 ^ x2;
    return (x1 + x2) ^ {f7, f3, 22'h2AAAAA};
  endfunction

  always_comb bus.fpu_y = fake_fpu(bus.fpu_funct7, bus.fpu_funct3, bus.fpu_x1, bus.fpu_x2);

  task automatic drive(input bit v, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] x1, input logic [31:0] x2, input logic [4:0] tag,
                       input bit rr, input bit fl);
    bus.req_valid  = v;
    bus.req_funct7 = f7;
    bus.req_funct3 = f3;
    bus.req_x1     = x1;
    bus.req_x2     = x2;
    bus.req_tag    = tag;
    bus.res_ready  = rr;
    bus.flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 7'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // One clock: sample req_ready, advance the model, cross the edge.
  task automatic tick();
    bit ev;
    #1;
    obs_ready = bus.req_ready;
    ev        = have_op && (cyc >= rdy_cyc);
    exp_ready = !bus.flush && (!have_op || (ev && bus.res_ready));
    if (bus.flush) begin
      have_op = 1'b0;
    end else if (bus.req_valid && exp_ready) begin
      have_op = 1'b1;
      rdy_cyc = cyc + 1 + ref_lat(bus.req_funct7);
      e_f7 = bus.req_funct7; e_f3 = bus.req_funct3;
      e_x1 = bus.req_x1;     e_x2 = bus.req_x2;  e_tag = bus.req_tag;
    end else if (ev && bus.res_ready) begin
      have_op = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    have_op = 1'b0;
    cyc++;
  endtask

  // Issue one op with res_ready low; lat = cycles from accept edge to res_valid (-1 on timeout).
  task automatic issue_and_wait(input logic [6:0] f7, input logic [31:0] x1, input logic [31:0] x2,
                                input logic [4:0] tag, output int lat, output bit held);
    drive(1'b1, f7, 3'd0, x1, x2, tag, 1'b0, 1'b0);
    tick();
    drive(1'b0, 7'h00, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    lat  = -1;
    held = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (bus.fpu_funct7 !== f7 || bus.fpu_x1 !== x1 || bus.fpu_x2 !== x2) held = 1'b0;
      tick();
      if (bus.res_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    #1;
    tot_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); else pass_cnt++;
    tot_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass_cnt++;
    tot_cnt++; if (bus.res_data !== 32'd0) $display("FAIL rst_res_data: got %h want 0", bus.res_data); else pass_cnt++;
    tot_cnt++; if (bus.res_tag !== 5'd0) $display("FAIL rst_res_tag: got %h want 0", bus.res_tag); else pass_cnt++;
    tot_cnt++; if (bus.res_illeg !== 1'b0) $display("FAIL rst_res_illeg: got %b want 0", bus.res_illeg); else pass_cnt++;
    tot_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); else pass_cnt++;
  endtask

  task automatic test_fadd();
    int lat; bit held;
    issue_and_wait(7'h00, 32'h3F800000, 32'h40000000, 5'd3, lat, held);
    tot_cnt++; if (lat !== 2) $display("FAIL fadd_lat: got %0d want 2", lat); else pass_cnt++;
    tot_cnt++; if (bus.res_data !== 32'h40400000) $display("FAIL fadd_data: got %h want 40400000", bus.res_data); else pass_cnt++;
    tot_cnt++; if (bus.res_tag !== 5'd3) $display("FAIL fadd_tag: got %0d want 3", bus.res_tag); else pass_cnt++;
    tot_cnt++; if (held !== 1'b1) $display("FAIL fadd_fpu_hold: got %b want 1", held); else pass_cnt++;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    tot_cnt++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL fadd_retire: got valid=%b busy=%b want 0 0", bus.res_valid, bus.busy); else pass_cnt++;
  endtask

  task automatic test_mul_div();
    int lat; bit held;
    issue_and_wait(7'h08, 32'h40000000, 32'h40400000, 5'd7, lat, held);
    tot_cnt++; if (lat !== 1) $display("FAIL fmul_lat: got %0d want 1", lat); else pass_cnt++;
    tot_cnt++; if (bus.res_data !== 32'h40C00000) $display("FAIL fmul_data: got %h want 40C00000", bus.res_data); else pass_cnt++;
    bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;
    issue_and_wait(7'h0C, 32'h40C00000, 32'h40000000, 5'd9, lat, held);
    tot_cnt++; if (lat !== 4) $display("FAIL fdiv_lat: got %0d want 4", lat); else pass_cnt++;
    tot_cnt++; if (bus.res_data !== 32'h40400000) $display("FAIL fdiv_data: got %h want 40400000", bus.res_data); else pass_cnt++;
    tot_cnt++; if (held !== 1'b1) $display("FAIL fdiv_fpu_hold: got %b want 1", held); else pass_cnt++;
    bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;
  endtask

  task automatic test_hold_back_to_back();
    int lat; bit held;
    logic [31:0] d0; logic [4:0] t0;
    issue_and_wait(7'h00, 32'h3F800000, 32'h40000000, 5'd12, lat, held);
    d0 = bus.res_data; t0 = bus.res_tag;
    // A waiting request must not slip in while the result is stalled.
    drive(1'b1, 7'h08, 3'd1, 32'h40000000, 32'h40400000, 5'd21, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      tot_cnt++; if (obs_ready !== 1'b0) $display("FAIL hold_req_ready: got %b want 0", obs_ready); else pass_cnt++;
      tot_cnt++; if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.res_tag !== t0)
        $display("FAIL hold_stable: got v=%b d=%h t=%0d want 1 %h %0d", bus.res_valid, bus.res_data, bus.res_tag, d0, t0);
      else pass_cnt++;
    end
    tot_cnt++; if (d0 !== 32'h40400000) $display("FAIL hold_data: got %h want 40400000", d0); else pass_cnt++;
    bus.res_ready = 1'b1;
    tick();
    tot_cnt++; if (obs_ready !== 1'b1) $display("FAIL b2b_accept: got %b want 1", obs_ready); else pass_cnt++;
    tot_cnt++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) $display("FAIL b2b_exec: got busy=%b v=%b want 1 0", bus.busy, bus.res_valid); else pass_cnt++;
    idle();
    tick();
    tot_cnt++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h40C00000 || bus.res_tag !== 5'd21)
      $display("FAIL b2b_result: got v=%b d=%h t=%0d want 1 40C00000 21", bus.res_valid, bus.res_data, bus.res_tag);
    else pass_cnt++;
    bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;
  endtask

  task automatic test_flush();
    bit rose = 1'b0;
    drive(1'b1, 7'h0C, 3'd0, 32'h40C00000, 32'h40000000, 5'd4, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b1, 7'h08, 3'd0, 32'h1, 32'h2, 5'd5, 1'b1, 1'b1);
    tick();
    tot_cnt++; if (obs_ready !== 1'b0) $display("FAIL flush_no_accept: got %b want 0", obs_ready); else pass_cnt++;
    idle();
    #1;
    tot_cnt++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL flush_idle: got busy=%b rdy=%b want 0 1", bus.busy, bus.req_ready); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (bus.res_valid !== 1'b0) rose = 1'b1;
      tick();
    end
    tot_cnt++; if (rose !== 1'b0) $display("FAIL flush_res_valid: got %b want 0", rose); else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    int lat; bit held;
    drive(1'b1, 7'h0C, 3'd0, 32'h40C00000, 32'h40000000, 5'd6, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    do_reset();
    tot_cnt++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res_data !== 32'd0)
      $display("FAIL rst_exec: got v=%b busy=%b d=%h want 0 0 0", bus.res_valid, bus.busy, bus.res_data);
    else pass_cnt++;
    issue_and_wait(7'h08, 32'h40000000, 32'h40400000, 5'd8, lat, held);
    tot_cnt++; if (bus.res_valid !== 1'b1) $display("FAIL rst_done_setup: got %b want 1", bus.res_valid); else pass_cnt++;
    do_reset();
    tot_cnt++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res_data !== 32'd0 || bus.res_tag !== 5'd0)
      $display("FAIL rst_done: got v=%b busy=%b d=%h t=%0d want 0 0 0 0", bus.res_valid, bus.busy, bus.res_data, bus.res_tag);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    int lat; bit held;
    issue_and_wait(7'h7F, 32'hAAAA0000, 32'h0000FFFF, 5'd17, lat, held);
    tot_cnt++; if (lat !== 1) $display("FAIL illeg_lat: got %0d want 1", lat); else pass_cnt++;
    tot_cnt++; if (bus.res_illeg !== 1'b1) $display("FAIL illeg_flag: got %b want 1", bus.res_illeg); else pass_cnt++;
    tot_cnt++; if (bus.res_data !== 32'hAAAAFFFF) $display("FAIL illeg_data: got %h want AAAAFFFF", bus.res_data); else pass_cnt++;
    bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] ops [11] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h2C, 7'h50, 7'h68, 7'h70, 7'h78, 7'h7F};
    logic [6:0] f7;
    bit ev;
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      drive(1'($urandom_range(0, 1)), f7, 3'($urandom), $urandom, $urandom, 5'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      tick();
      ev = have_op && (cyc >= rdy_cyc);
      tot_cnt++; if (obs_ready !== exp_ready) $display("FAIL rnd_req_ready: cyc %0d got %b want %b", cyc, obs_ready, exp_ready); else pass_cnt++;
      tot_cnt++; if (bus.res_valid !== ev || bus.busy !== have_op)
        $display("FAIL rnd_state: cyc %0d got v=%b busy=%b want %b %b", cyc, bus.res_valid, bus.busy, ev, have_op);
      else pass_cnt++;
      if (ev) begin
        tot_cnt++;
        if (bus.res_data !== fake_fpu(e_f7, e_f3, e_x1, e_x2) || bus.res_tag !== e_tag || bus.res_illeg !== ref_illeg(e_f7))
          $display("FAIL rnd_result: cyc %0d got d=%h t=%0d i=%b want %h %0d %b", cyc, bus.res_data, bus.res_tag,
                   bus.res_illeg, fake_fpu(e_f7, e_f3, e_x1, e_x2), e_tag, ref_illeg(e_f7));
        else pass_cnt++;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    do_reset();
    test_reset();
    test_fadd();
    test_mul_div();
    test_hold_back_to_back();
    test_flush();
    test_rst_mid();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
